// File: rtl/drive_state_tracker_if.sv
// Bundle between the drive controller, the state tracker and the display/LED logic.
// Latency: none, wires only; the tracker registers every output it drives.
// Backpressure: none; requests are levels and the tracker samples them every cycle.
interface drive_state_tracker_if #(
  parameter int MILE_W = 24
);
  // Mode and power buttons
  logic              enable;
  logic              power_on;
  logic              power_off;
  // Controller requests
  logic [1:0]        state_next;
  logic              brake_off;
  logic              move_forward;
  logic              move_backward;
  logic              turn_left;
  logic              turn_right;
  // Tracker results
  logic [1:0]        state_cur;
  logic [MILE_W-1:0] mileage;
  logic [1:0]        motion;
  logic              tick;
  logic              led_left;
  logic              led_right;

  // Controller side: drives requests, consumes the state feedback and displays
  modport master (
    output enable, power_on, power_off, state_next, brake_off,
           move_forward, move_backward, turn_left, turn_right,
    input  state_cur, mileage, motion, tick, led_left, led_right
  );

  // Tracker side
  modport slave (
    input  enable, power_on, power_off, state_next, brake_off,
           move_forward, move_backward, turn_left, turn_right,
    output state_cur, mileage, motion, tick, led_left, led_right
  );
endinterface

// File: rtl/drive_state_tracker.sv
// Registers the drive controller's next state and turns its requests into odometer, motion tick and blinking lamps.
// Latency: state, motion and lamp request appear 1 cycle after the inputs; power-on needs POWER_HOLD held cycles.
// Backpressure: none; every input is sampled each cycle and outputs are always valid.
module drive_state_tracker #(
  parameter int TICK_DIV   = 100_000_000,
  parameter int BLINK_DIV  = 50_000_000,
  parameter int POWER_HOLD = 100_000_000,
  parameter int MILE_W     = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  drive_state_tracker_if.slave  bus
);

  typedef enum logic [1:0] {
    OFF          = 2'b00,
    NOT_STARTING = 2'b01,
    STARTING     = 2'b11,
    MOVING       = 2'b10
  } drive_state_t;

  localparam int TICK_W  = $clog2(TICK_DIV);
  localparam int BLINK_W = $clog2(BLINK_DIV);
  localparam int HOLD_W  = (POWER_HOLD > 1) ? $clog2(POWER_HOLD) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(POWER_HOLD - 1);

  drive_state_t       state, state_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic               power_up;

  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic [1:0]         motion;
  logic [MILE_W-1:0]  mileage;

  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;
  logic               req_l, req_r;
  logic               lamp_ok, nreq_l, nreq_r;

  // State register and power-hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OFF;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Next state: power-off beats brake, brake beats power-on hold, hold beats the controller's request
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    power_up  = 1'b0;
    if (bus.power_off) begin
      state_nxt = OFF;
      hold_nxt  = '0;
    end else if (bus.enable && (state != OFF) && bus.brake_off) begin
      state_nxt = OFF;
    end else if (state == OFF) begin
      if (bus.power_on) begin
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = NOT_STARTING;
          hold_nxt  = '0;
          power_up  = 1'b1;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end else begin
        hold_nxt = '0;
      end
    end else if (bus.enable) begin
      state_nxt = drive_state_t'(bus.state_next);
    end
  end

  // Free-running motion tick; pulse lands in the cycle after the counter's last value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick     <= (tick_cnt == TICK_LAST);
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    end
  end

  // Motion direction, only while enabled and actually moving; conflicting requests cancel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      motion <= 2'b00;
    end else if (bus.enable && (state == MOVING)) begin
      motion <= {bus.move_forward & ~bus.move_backward,
                 bus.move_backward & ~bus.move_forward};
    end else begin
      motion <= 2'b00;
    end
  end

  // Saturating odometer; a fresh power-on starts the trip at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mileage <= '0;
    end else if (power_up) begin
      mileage <= '0;
    end else if (tick && (motion != 2'b00) && (mileage != '1)) begin
      mileage <= mileage + 1'b1;
    end
  end

  // Lamps only respond while enabled and powered; both directions at once means neither
  assign lamp_ok = bus.enable && (state != OFF);
  assign nreq_l  = lamp_ok && bus.turn_left  && !bus.turn_right;
  assign nreq_r  = lamp_ok && bus.turn_right && !bus.turn_left;

  // Blink timer: a newly requested direction restarts lit, then toggles every BLINK_DIV cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_l     <= 1'b0;
      req_r     <= 1'b0;
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      req_l <= nreq_l;
      req_r <= nreq_r;
      if (!(nreq_l || nreq_r)) begin
        blink_cnt <= '0;
        phase     <= 1'b0;
      end else if ((nreq_l && !req_l) || (nreq_r && !req_r)) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign bus.state_cur = state;
  assign bus.mileage   = mileage;
  assign bus.motion    = motion;
  assign bus.tick      = tick;
  assign bus.led_left  = req_l & phase;
  assign bus.led_right = req_r & phase;

endmodule

// File: tb/tb_drive_state_tracker.sv
// Directed check of the drive state tracker with small dividers (tick 4, blink 3, hold 5, 4-bit odometer).
// Latency: inputs are applied just after a rising edge and outputs sampled 1 time unit later.
// Backpressure: not applicable; the bench drives levels only.
module tb_drive_state_tracker;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [6:0] blink_pat;

  drive_state_tracker_if #(.MILE_W(4)) bus ();

  drive_state_tracker #(
    .TICK_DIV  (4),
    .BLINK_DIV (3),
    .POWER_HOLD(5),
    .MILE_W    (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    bus.enable = 1'b0;  bus.power_on = 1'b0;  bus.power_off = 1'b0;
    bus.state_next = 2'b00;  bus.brake_off = 1'b0;
    bus.move_forward = 1'b0; bus.move_backward = 1'b0;
    bus.turn_left = 1'b0;    bus.turn_right = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_state",   32'(bus.state_cur), 0);
    chk("rst_mileage", 32'(bus.mileage),   0);
    chk("rst_motion",  32'(bus.motion),    0);
    chk("rst_tick",    32'(bus.tick),      0);
    chk("rst_leds",    32'({bus.led_left, bus.led_right}), 0);
    #9 rst_n = 1'b1;
    cyc(1);
    chk("idle_off", 32'(bus.state_cur), 0);

    // power_on together with power_off stays OFF
    bus.power_on = 1'b1; bus.power_off = 1'b1;
    cyc(6);
    chk("on_off_both", 32'(bus.state_cur), 0);

    // Hold for 4 only, release, hold 4 again: counter must have restarted
    bus.power_off = 1'b0;
    cyc(4);
    chk("hold4_off", 32'(bus.state_cur), 0);
    bus.power_on = 1'b0;
    cyc(1);
    chk("release_off", 32'(bus.state_cur), 0);
    bus.power_on = 1'b1;
    cyc(4);
    chk("rehold4_off", 32'(bus.state_cur), 0);
    cyc(1);
    chk("hold5_on", 32'(bus.state_cur), 1);
    chk("on_mileage", 32'(bus.mileage), 0);
    bus.power_on = 1'b0;

    // Controller moves the state to MOVING
    bus.enable = 1'b1; bus.state_next = 2'b10;
    cyc(1);
    chk("to_moving", 32'(bus.state_cur), 2);
    chk("motion_pre", 32'(bus.motion), 0);

    // Forward for 12 cycles: 3 ticks -> mileage 3
    bus.move_forward = 1'b1;
    cyc(1);
    chk("motion_fwd", 32'(bus.motion), 2);
    cyc(11);
    bus.move_forward = 1'b0;
    cyc(1);
    chk("motion_stop", 32'(bus.motion), 0);
    chk("mileage_3", 32'(bus.mileage), 3);

    // Tick is a single-cycle pulse every 4 cycles
    for (int i = 0; i < 8; i++) begin
      if (bus.tick) break;
      cyc(1);
    end
    chk("tick_seen", 32'(bus.tick), 1);
    cyc(1);
    chk("tick_low", 32'(bus.tick), 0);
    cyc(3);
    chk("tick_period", 32'(bus.tick), 1);

    // Drive up to 4'hE, then past the top: saturate at 4'hF
    bus.move_forward = 1'b1;
    cyc(44);
    bus.move_forward = 1'b0;
    cyc(1);
    chk("mileage_E", 32'(bus.mileage), 14);
    bus.move_forward = 1'b1;
    cyc(12);
    chk("motion_fwd2", 32'(bus.motion), 2);
    bus.move_forward = 1'b0;
    cyc(1);
    chk("mileage_F", 32'(bus.mileage), 15);
    bus.move_forward = 1'b1;
    cyc(8);
    chk("mileage_sat", 32'(bus.mileage), 15);

    // Both directions cancel; backward alone
    bus.move_backward = 1'b1;
    cyc(1);
    chk("motion_both", 32'(bus.motion), 0);
    bus.move_forward = 1'b0;
    cyc(1);
    chk("motion_bwd", 32'(bus.motion), 1);

    // enable=0 freezes state and kills motion
    bus.enable = 1'b0; bus.state_next = 2'b01;
    cyc(1);
    chk("dis_motion", 32'(bus.motion), 0);
    cyc(2);
    chk("dis_state", 32'(bus.state_cur), 2);

    // Brake forces OFF, mileage kept; OFF ignores state_next
    bus.enable = 1'b1; bus.state_next = 2'b10;
    bus.move_backward = 1'b0; bus.brake_off = 1'b1;
    cyc(1);
    chk("brake_state",   32'(bus.state_cur), 0);
    chk("brake_motion",  32'(bus.motion),    0);
    chk("brake_mileage", 32'(bus.mileage),   15);
    bus.brake_off = 1'b0;
    cyc(1);
    chk("off_ignores_next", 32'(bus.state_cur), 0);

    // Power on again clears the odometer
    bus.power_on = 1'b1;
    cyc(5);
    chk("repower_state",   32'(bus.state_cur), 1);
    chk("repower_mileage", 32'(bus.mileage),   0);
    bus.power_on = 1'b0;
    cyc(1);
    chk("moving_again", 32'(bus.state_cur), 2);

    // Left lamp blink: 1,1,1,0,0,0,1
    blink_pat = 7'b1000111;
    bus.turn_left = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc(1);
      chk($sformatf("blink_l%0d", i), 32'(bus.led_left), 32'(blink_pat[i]));
      chk($sformatf("blink_r%0d", i), 32'(bus.led_right), 0);
    end

    // Both turn requests: neither lamp
    bus.turn_right = 1'b1;
    cyc(1);
    chk("both_turn", 32'({bus.led_left, bus.led_right}), 0);

    // Left, then directly right: right restarts lit
    bus.turn_right = 1'b0;
    cyc(1);
    chk("left_restart", 32'({bus.led_left, bus.led_right}), 2);
    cyc(1);
    chk("left_hold", 32'({bus.led_left, bus.led_right}), 2);
    bus.turn_left = 1'b0; bus.turn_right = 1'b1;
    cyc(1);
    chk("switch_right", 32'({bus.led_left, bus.led_right}), 1);

    // Async reset while blinking and moving
    bus.move_forward = 1'b1;
    cyc(2);
    chk("pre_rst_motion", 32'(bus.motion), 2);
    chk("pre_rst_led",    32'(bus.led_right), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state",   32'(bus.state_cur), 0);
    chk("arst_motion",  32'(bus.motion),    0);
    chk("arst_mileage", 32'(bus.mileage),   0);
    chk("arst_tick",    32'(bus.tick),      0);
    chk("arst_leds",    32'({bus.led_left, bus.led_right}), 0);
    bus.move_forward = 1'b0; bus.turn_right = 1'b0;
    #3 rst_n = 1'b1;
    cyc(2);
    chk("post_rst_state", 32'(bus.state_cur), 0);
    chk("post_rst_leds",  32'({bus.led_left, bus.led_right}), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
